// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a byte FIFO.
// Byte stores to UART_ADDR are queued. UART_ADDR+4 reads a status word,
// and writing 1 to bit 0 of that address clears drop_cnt.
// Optional macro UART_TX_SIM_PRINT_EN echoes each popped byte to the
// simulation console.
module uart_tx_mmio #(
  parameter logic [31:0] UART_ADDR  = 32'h1000_0000,
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        tx_busy,
  output logic        fifo_full,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLK_DIV);
  localparam logic [31:0] CTRL_ADDR = UART_ADDR + 32'd4;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t            state, state_nxt;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [BAUD_W-1:0] baud, baud_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [7:0]        shift, shift_nxt;
  logic              tx_nxt;
  logic              push_req, ctrl_clr, pop, accept, empty, bit_end;
  logic              unused_din;

  assign unused_din = ^din[31:8];

  // Bus decode and FIFO handshake.
  always_comb begin
    push_req  = we && (addr == UART_ADDR);
    ctrl_clr  = we && (addr == CTRL_ADDR) && din[0];
    empty     = (count == '0);
    fifo_full = (count == CNT_W'(FIFO_DEPTH));
    pop       = (state == S_IDLE) && !empty;
    // A full FIFO still takes a byte when the head is popped in the same cycle.
    accept    = push_req && (!fifo_full || pop);
    bit_end   = (baud == BAUD_W'(CLK_DIV - 1));
    tx_busy   = (state != S_IDLE) || !empty;
  end

  // Status register read, combinational from the address.
  always_comb begin
    rdata = '0;
    if (addr == CTRL_ADDR) begin
      rdata[0]           = tx_busy;
      rdata[1]           = empty;
      rdata[2]           = fifo_full;
      rdata[8 +: CNT_W]  = count;
      rdata[23:16]       = drop_cnt;
    end
  end

  // FIFO storage; written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= din[7:0];
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Saturating drop counter; a clear wins over an increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (ctrl_clr) begin
      drop_cnt <= '0;
    end else if (push_req && !accept && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Transmit FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      baud    <= baud_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      tx      <= tx_nxt;
    end
  end

  // Next-state logic; tx is registered from the current state, so the line
  // lags the state by one cycle for every slot and frame length is unchanged.
  always_comb begin
    state_nxt   = state;
    baud_nxt    = baud;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    tx_nxt      = 1'b1;
    case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        if (pop) begin
          shift_nxt   = mem[rd_ptr];
          baud_nxt    = '0;
          bit_idx_nxt = '0;
          state_nxt   = S_START;
        end
      end
      S_START: begin
        tx_nxt = 1'b0;
        if (bit_end) begin
          baud_nxt    = '0;
          bit_idx_nxt = '0;
          state_nxt   = S_DATA;
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      S_DATA: begin
        tx_nxt = shift[0];
        if (bit_end) begin
          baud_nxt  = '0;
          shift_nxt = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_nxt = S_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      S_STOP: begin
        tx_nxt = 1'b1;
        if (bit_end) begin
          baud_nxt  = '0;
          state_nxt = S_IDLE;
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef UART_TX_SIM_PRINT_EN
  // Console echo of every byte as it leaves the FIFO.
  always_ff @(posedge clk) begin
    if (!rst && pop) $write("%c", mem[rd_ptr]);
  end
`else
`endif

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: directed scenarios plus random bus traffic, every
// cycle compared against a queue-based model of the transmitter.
module tb_uart_tx_mmio;

  localparam logic [31:0] UA    = 32'h1000_0000;
  localparam logic [31:0] CA    = 32'h1000_0004;
  localparam int          D     = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * D;
  localparam int          BIG   = 100000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] din = '0;
  logic        we = 1'b0;
  logic [31:0] rdata;
  logic        tx, tx_busy, fifo_full;
  logic [7:0]  drop_cnt;

  int compared = 0;
  int mismatched = 0;

  // Model state: pending bytes, cycles since the last pop, byte in flight.
  logic [7:0] q[$];
  int         since_pop = BIG;
  logic [7:0] cur = '0;
  logic [7:0] drop_m = '0;

  uart_tx_mmio #(.UART_ADDR(UA), .CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .we(we),
    .rdata(rdata), .tx(tx), .tx_busy(tx_busy), .fifo_full(fifo_full),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic m_busy();
    return (since_pop < FRAME) || (q.size() > 0);
  endfunction

  // Line level one cycle after each frame slot: start, 8 data LSB first, stop.
  function automatic logic m_tx();
    int slot;
    if (since_pop >= 1 && since_pop <= FRAME) begin
      slot = (since_pop - 1) / D;
      if (slot == 0) return 1'b0;
      if (slot == 9) return 1'b1;
      return cur[slot-1];
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] a);
    logic [7:0] cnt8;
    cnt8 = 8'(q.size());
    if (a != CA) return '0;
    return {8'h00, drop_m, cnt8, 5'b0, (q.size() == DEPTH), (q.size() == 0), m_busy()};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of bus activity, advance the model across the edge,
  // then compare every output after the edge.
  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic pop, acc, preq, clr;
    rst = r; we = w; addr = a; din = d;
    @(posedge clk);
    if (r) begin
      q.delete();
      since_pop = BIG;
      drop_m = '0;
    end else begin
      preq = w && (a == UA);
      clr  = w && (a == CA) && d[0];
      pop  = (since_pop >= FRAME) && (q.size() > 0);
      acc  = preq && ((q.size() < DEPTH) || pop);
      if (pop) begin
        cur = q.pop_front();
        since_pop = 0;
      end else if (since_pop < BIG) begin
        since_pop++;
      end
      if (acc) q.push_back(d[7:0]);
      if (clr) drop_m = '0;
      else if (preq && !acc && drop_m != 8'hFF) drop_m = drop_m + 8'd1;
    end
    #1;
    check("tx", {31'b0, tx}, {31'b0, m_tx()});
    check("tx_busy", {31'b0, tx_busy}, {31'b0, m_busy()});
    check("fifo_full", {31'b0, fifo_full}, {31'b0, (q.size() == DEPTH)});
    check("drop_cnt", {24'b0, drop_cnt}, {24'b0, drop_m});
    check("rdata", rdata, m_rdata(a));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, CA, 32'h0);
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  saved_drop;

    // Reset and idle state.
    step(1'b1, 1'b0, CA, 32'h0);
    check("reset_tx", {31'b0, tx}, 32'd1);
    check("reset_status", rdata, 32'h0000_0002);

    // Single byte: tx falls two edges after the write.
    step(1'b0, 1'b1, UA, 32'hFFFF_FF41);
    step(1'b0, 1'b0, CA, 32'h0);
    check("single_pre_start", {31'b0, tx}, 32'd1);
    step(1'b0, 1'b0, CA, 32'h0);
    check("single_start", {31'b0, tx}, 32'd0);
    idle(FRAME + 5);
    check("single_done_busy", {31'b0, tx_busy}, 32'd0);

    // Back-to-back frames; one byte waits during the first frame.
    step(1'b0, 1'b1, UA, 32'h55);
    step(1'b0, 1'b1, UA, 32'hAA);
    step(1'b0, 1'b0, CA, 32'h0);
    r = rdata;
    check("b2b_count", {24'b0, r[15:8]}, 32'd1);
    idle(2 * FRAME + 5);

    // Overflow: six writes, five accepted, one dropped.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, UA, 32'h30 + 32'(i));
    check("ovf_drop", {24'b0, drop_cnt}, 32'd1);
    check("ovf_full", {31'b0, fifo_full}, 32'd1);
    step(1'b0, 1'b1, UA, 32'h77);
    step(1'b0, 1'b1, UA, 32'h78);

    // Status and control register.
    step(1'b0, 1'b0, CA, 32'h0);
    r = rdata;
    check("status_drop3", {24'b0, r[23:16]}, 32'd3);
    step(1'b0, 1'b1, CA, 32'h1);
    step(1'b0, 1'b0, CA, 32'h0);
    r = rdata;
    check("status_drop_clr", {24'b0, r[23:16]}, 32'd0);
    step(1'b0, 1'b0, 32'h1000_0008, 32'h0);
    check("other_addr", rdata, 32'h0);

    // Full FIFO with a write landing exactly on the pop edge.
    for (int i = 0; i < 3 * FRAME && since_pop < FRAME; i++) idle(1);
    saved_drop = drop_cnt;
    step(1'b0, 1'b1, UA, 32'h5A);
    check("fullpop_drop", {24'b0, drop_cnt}, {24'b0, saved_drop});
    step(1'b0, 1'b0, CA, 32'h0);
    r = rdata;
    check("fullpop_count", {24'b0, r[15:8]}, DEPTH);
    idle(6 * FRAME);

    // Random bus traffic.
    for (int i = 0; i < 600; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 99);
      if (sel < 25)      step(1'b0, 1'b1, UA, $urandom);
      else if (sel < 30) step(1'b0, 1'b1, CA, $urandom);
      else if (sel < 40) step(1'b0, 1'b1, $urandom, $urandom);
      else if (sel < 60) step(1'b0, 1'b0, CA, $urandom);
      else               step(1'b0, 1'b0, $urandom, $urandom);
    end
    idle(6 * FRAME);

    // Reset during data bit 3 aborts the frame.
    step(1'b0, 1'b1, UA, 32'hC3);
    for (int i = 0; i < 3 * FRAME && since_pop != 4 * D + 1; i++) idle(1);
    step(1'b1, 1'b0, CA, 32'h0);
    check("midrst_tx", {31'b0, tx}, 32'd1);
    check("midrst_busy", {31'b0, tx_busy}, 32'd0);
    r = rdata;
    check("midrst_count", {24'b0, r[15:8]}, 32'd0);
    idle(2 * FRAME);
    check("midrst_quiet", {31'b0, tx}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
